decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have the following ports, one clock and an asynchronous active-high reset:
- clk in 1: rising-edge clock.
- reset in 1: asynchronous, active-high.
- IPCP2 in 16: incoming PC+2.
- pc_in in 16: PC of the instruction.
- ir_in in 16: instruction word.
- loadAddr in 4: register-file write address.
- loadData in 16: register-file write data.
- rf_write in 1: register-file write enable.
- comparatorMux1Control in 1: selects comparator operand A; 1 = forward.
- comparatorMux2Control in 1: selects comparator operand B; 1 = forward.
- comparatorMuxForward in 16: forwarded comparator value.
- RegWrite, ALUSrc, MemWrite, MemRead, RegStore out 1 each: control signals.
- ALUOp out 3: ALU operation.
- OPCP2 out 16: registered PC+2.
- Arg1, Arg2, Arg3 out 16: R[Rs1], R[Rs2], R[Rd].
- Imm out 16: sign-extended immediate.
- Rs1, Rs2, Rd out 3: register fields.
- new_pc out 16: branch/jump target.
- jump out 1: redirect taken.

Function
REQ-002 Every output SHALL be registered, updating on the clk rising edge from the current inputs (1-cycle latency).
REQ-003 The register file SHALL hold 8 x 16-bit registers; R0 SHALL always read 0.
REQ-004 A register SHALL be written on the clk rising edge when rf_write=1: R[loadAddr[2:0]] <= loadData. Writes with loadAddr[3]=1 or loadAddr[2:0]=0 SHALL be ignored.
REQ-005 Register reads SHALL be write-first: a same-cycle write to the read address supplies loadData.
REQ-006 The instruction fields SHALL be: opcode = ir[15:12], rd = ir[11:9], rs1 = ir[8:6], rs2 = ir[5:3], funct = ir[2:0]. The Rs1, Rs2 and Rd outputs SHALL be the raw fields for every opcode.
REQ-007 The opcode decode SHALL be as follows; controls not listed are 0:
- 0x0 NOP: all controls 0, Imm = 0.
- 0x1 R-type: RegWrite=1, ALUOp=funct.
- 0x2 ADDI: RegWrite=1, ALUSrc=1, ALUOp=000, Imm=sext(ir[5:0]).
- 0x3 LW: RegWrite=1, ALUSrc=1, MemRead=1, ALUOp=000, Imm=sext(ir[5:0]).
- 0x4 SW: MemWrite=1, ALUSrc=1, RegStore=1, ALUOp=000, Imm=sext(ir[5:0]).
- 0x5 BEQ and 0x6 BNE: Imm=sext({ir[11:9],ir[2:0]}).
- 0x7 JAL: RegWrite=1, ALUOp=110, Imm=sext(ir[8:0]), jump=1.
- 0x8 LUI: RegWrite=1, ALUSrc=1, ALUOp=110, Imm={ir[8:0],7'b0}.
- 0x9-0xF: decode as NOP.
REQ-008 The ALUOp encoding SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 pass-B, 111 slt.
REQ-009 The comparator operands SHALL be selected as follows:
- A = comparatorMux1Control ? comparatorMuxForward : R[rs1].
- B = comparatorMux2Control ? comparatorMuxForward : R[rs2].
REQ-010 jump SHALL be 1 for BEQ with A==B, for BNE with A!=B, and for JAL; otherwise 0.
REQ-011 new_pc SHALL be pc_in + (Imm << 1), modulo 2^16 (wrap), for every opcode. With Imm=0, new_pc = pc_in.
REQ-012 OPCP2 SHALL equal the IPCP2 input registered.
REQ-013 Imm SHALL be 0 for opcodes without an immediate.

Reset
REQ-014 Asserting reset SHALL immediately clear all outputs and all 8 registers to 0, independent of clk.
REQ-015 While reset=1, clock edges SHALL change no state, including register-file writes.
REQ-016 After reset is released, the first update SHALL occur on the next rising clk edge.

Verification
REQ-017 Reset scenario: hold reset for 2 cycles -> every output is 0.
REQ-018 PC+2 scenario: release reset; IPCP2=200, ir_in=0, pc_in=0, rf_write=1, loadAddr=0; 1 clock -> OPCP2=200, all other outputs 0.
REQ-019 Target scenario: IPCP2=0, pc_in=13, ir_in=0; 1 clock -> new_pc=13, jump=0, all other outputs 0.
REQ-020 Write/read scenario: write R3=0x1234 (rf_write=1, loadAddr=3); then ir_in=0x10D8 (R-type, rd=0, rs1=3, rs2=3, funct=0) -> Arg1=Arg2=0x1234, RegWrite=1, ALUOp=000.
REQ-021 Branch scenario: R1=R2=5, ir_in=BEQ rs1=1 rs2=2 Imm=-2, pc_in=0x0010 -> jump=1, new_pc=0x000C. With comparatorMux1Control=1 and comparatorMuxForward=6 -> jump=0.
REQ-022 Asynchronous reset scenario: assert reset mid-cycle after a load -> outputs are 0 without a clock edge, and the register file is cleared.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: register file, instruction decode, immediate generation,
// branch comparator and target computation. Every output is registered.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IPCP2,
    input  logic [15:0] pc_in,
    input  logic [15:0] ir_in,
    input  logic [3:0]  loadAddr,
    input  logic [15:0] loadData,
    input  logic        rf_write,
    input  logic        comparatorMux1Control,
    input  logic        comparatorMux2Control,
    input  logic [15:0] comparatorMuxForward,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        RegStore,
    output logic [2:0]  ALUOp,
    output logic [15:0] OPCP2,
    output logic [15:0] Arg1,
    output logic [15:0] Arg2,
    output logic [15:0] Arg3,
    output logic [15:0] Imm,
    output logic [2:0]  Rs1,
    output logic [2:0]  Rs2,
    output logic [2:0]  Rd,
    output logic [15:0] new_pc,
    output logic        jump
);

    localparam logic [3:0] OP_RTYPE = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_LW    = 4'h3;
    localparam logic [3:0] OP_SW    = 4'h4;
    localparam logic [3:0] OP_BEQ   = 4'h5;
    localparam logic [3:0] OP_BNE   = 4'h6;
    localparam logic [3:0] OP_JAL   = 4'h7;
    localparam logic [3:0] OP_LUI   = 4'h8;

    // R0 is hardwired to zero, so only R1..R7 are stored
    logic [15:0] regs_q [1:7];

    logic [3:0]  opcode;
    logic [2:0]  f_rd, f_rs1, f_rs2, funct;
    logic        wr_en;
    logic [15:0] rd_rs1, rd_rs2, rd_rd, cmp_a, cmp_b;

    logic        regwrite_d, alusrc_d, memwrite_d, memread_d, regstore_d, jump_d;
    logic [2:0]  aluop_d;
    logic [15:0] imm_d, new_pc_d;

    logic        regwrite_q, alusrc_q, memwrite_q, memread_q, regstore_q, jump_q;
    logic [2:0]  aluop_q, rs1_q, rs2_q, rd_q;
    logic [15:0] opcp2_q, arg1_q, arg2_q, arg3_q, imm_q, new_pc_q;

    assign opcode = ir_in[15:12];
    assign f_rd   = ir_in[11:9];
    assign f_rs1  = ir_in[8:6];
    assign f_rs2  = ir_in[5:3];
    assign funct  = ir_in[2:0];

    // Writes to R0 or to the upper (nonexistent) address half are dropped
    assign wr_en = rf_write && !loadAddr[3] && (loadAddr[2:0] != 3'd0);

    // Write-first read: a same-cycle write to the address bypasses the array
    function automatic logic [15:0] rf_read(input logic [2:0] a);
        if (a == 3'd0)
            return 16'h0000;
        else if (wr_en && loadAddr[2:0] == a)
            return loadData;
        else
            return regs_q[a];
    endfunction

    assign rd_rs1 = rf_read(f_rs1);
    assign rd_rs2 = rf_read(f_rs2);
    assign rd_rd  = rf_read(f_rd);

    assign cmp_a = comparatorMux1Control ? comparatorMuxForward : rd_rs1;
    assign cmp_b = comparatorMux2Control ? comparatorMuxForward : rd_rs2;

    // Opcode decode into controls, immediate and redirect decision
    always_comb begin
        regwrite_d = 1'b0;
        alusrc_d   = 1'b0;
        memwrite_d = 1'b0;
        memread_d  = 1'b0;
        regstore_d = 1'b0;
        jump_d     = 1'b0;
        aluop_d    = 3'b000;
        imm_d      = 16'h0000;
        case (opcode)
            OP_RTYPE: begin
                regwrite_d = 1'b1;
                aluop_d    = funct;
            end
            OP_ADDI: begin
                regwrite_d = 1'b1;
                alusrc_d   = 1'b1;
                imm_d      = {{10{ir_in[5]}}, ir_in[5:0]};
            end
            OP_LW: begin
                regwrite_d = 1'b1;
                alusrc_d   = 1'b1;
                memread_d  = 1'b1;
                imm_d      = {{10{ir_in[5]}}, ir_in[5:0]};
            end
            OP_SW: begin
                memwrite_d = 1'b1;
                alusrc_d   = 1'b1;
                regstore_d = 1'b1;
                imm_d      = {{10{ir_in[5]}}, ir_in[5:0]};
            end
            OP_BEQ: begin
                imm_d  = {{10{ir_in[11]}}, ir_in[11:9], ir_in[2:0]};
                jump_d = (cmp_a == cmp_b);
            end
            OP_BNE: begin
                imm_d  = {{10{ir_in[11]}}, ir_in[11:9], ir_in[2:0]};
                jump_d = (cmp_a != cmp_b);
            end
            OP_JAL: begin
                regwrite_d = 1'b1;
                aluop_d    = 3'b110;
                imm_d      = {{7{ir_in[8]}}, ir_in[8:0]};
                jump_d     = 1'b1;
            end
            OP_LUI: begin
                regwrite_d = 1'b1;
                alusrc_d   = 1'b1;
                aluop_d    = 3'b110;
                imm_d      = {ir_in[8:0], 7'b0};
            end
            default: ;
        endcase
    end

    // Target is always computed (wraps at 16 bits); jump qualifies it
    assign new_pc_d = pc_in + (imm_d << 1);

    // Register file update; reset clears it and blocks writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 8; i++) regs_q[i] <= 16'h0000;
        end else if (wr_en) begin
            regs_q[loadAddr[2:0]] <= loadData;
        end
    end

    // Output pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            alusrc_q   <= 1'b0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            regstore_q <= 1'b0;
            jump_q     <= 1'b0;
            aluop_q    <= 3'b000;
            rs1_q      <= 3'b000;
            rs2_q      <= 3'b000;
            rd_q       <= 3'b000;
            opcp2_q    <= 16'h0000;
            arg1_q     <= 16'h0000;
            arg2_q     <= 16'h0000;
            arg3_q     <= 16'h0000;
            imm_q      <= 16'h0000;
            new_pc_q   <= 16'h0000;
        end else begin
            regwrite_q <= regwrite_d;
            alusrc_q   <= alusrc_d;
            memwrite_q <= memwrite_d;
            memread_q  <= memread_d;
            regstore_q <= regstore_d;
            jump_q     <= jump_d;
            aluop_q    <= aluop_d;
            rs1_q      <= f_rs1;
            rs2_q      <= f_rs2;
            rd_q       <= f_rd;
            opcp2_q    <= IPCP2;
            arg1_q     <= rd_rs1;
            arg2_q     <= rd_rs2;
            arg3_q     <= rd_rd;
            imm_q      <= imm_d;
            new_pc_q   <= new_pc_d;
        end
    end

    assign RegWrite = regwrite_q;
    assign ALUSrc   = alusrc_q;
    assign MemWrite = memwrite_q;
    assign MemRead  = memread_q;
    assign RegStore = regstore_q;
    assign ALUOp    = aluop_q;
    assign OPCP2    = opcp2_q;
    assign Arg1     = arg1_q;
    assign Arg2     = arg2_q;
    assign Arg3     = arg3_q;
    assign Imm      = imm_q;
    assign Rs1      = rs1_q;
    assign Rs2      = rs2_q;
    assign Rd       = rd_q;
    assign new_pc   = new_pc_q;
    assign jump     = jump_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model predicts the packed
// output word for each driven cycle; predictions are queued and compared
// one cycle later.
module tb_decode_stage;

    typedef logic [113:0] vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] IPCP2, pc_in, ir_in, loadData, comparatorMuxForward;
    logic [3:0]  loadAddr;
    logic        rf_write, comparatorMux1Control, comparatorMux2Control;
    logic        RegWrite, ALUSrc, MemWrite, MemRead, RegStore, jump;
    logic [2:0]  ALUOp, Rs1, Rs2, Rd;
    logic [15:0] OPCP2, Arg1, Arg2, Arg3, Imm, new_pc;

    int   checks = 0;
    int   errors = 0;
    vec_t sb_q[$];
    logic [15:0] mregs [8];

    decode_stage dut (
        .clk(clk), .reset(reset), .IPCP2(IPCP2), .pc_in(pc_in), .ir_in(ir_in),
        .loadAddr(loadAddr), .loadData(loadData), .rf_write(rf_write),
        .comparatorMux1Control(comparatorMux1Control),
        .comparatorMux2Control(comparatorMux2Control),
        .comparatorMuxForward(comparatorMuxForward),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead),
        .RegStore(RegStore), .ALUOp(ALUOp), .OPCP2(OPCP2), .Arg1(Arg1), .Arg2(Arg2),
        .Arg3(Arg3), .Imm(Imm), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .new_pc(new_pc), .jump(jump)
    );

    always #5 clk = ~clk;

    function automatic vec_t observed();
        return {RegWrite, ALUSrc, MemWrite, MemRead, RegStore, ALUOp, OPCP2,
                Arg1, Arg2, Arg3, Imm, Rs1, Rs2, Rd, new_pc, jump};
    endfunction

    task automatic chk(input string tag, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference read of the model register file, honouring write-first
    function automatic logic [15:0] mread(input logic [2:0] a);
        if (rf_write && loadAddr[3] == 1'b0 && loadAddr[2:0] == a && a != 3'd0)
            return loadData;
        return (a == 3'd0) ? 16'h0000 : mregs[a];
    endfunction

    // Build the expected output word from the current inputs
    function automatic vec_t predict();
        logic [2:0]  fd, f1, f2, op3;
        logic [15:0] a1, a2, a3, ca, cb, im, tgt;
        logic        rw, as, mw, mr, rs, jp;
        logic signed [15:0] s;
        fd = ir_in[11:9]; f1 = ir_in[8:6]; f2 = ir_in[5:3];
        a1 = mread(f1); a2 = mread(f2); a3 = mread(fd);
        ca = comparatorMux1Control ? comparatorMuxForward : a1;
        cb = comparatorMux2Control ? comparatorMuxForward : a2;
        {rw, as, mw, mr, rs, jp} = 6'b0;
        op3 = 3'd0;
        im  = 16'd0;
        if (ir_in[15:12] == 4'd1) begin
            rw = 1; op3 = ir_in[2:0];
        end else if (ir_in[15:12] >= 4'd2 && ir_in[15:12] <= 4'd4) begin
            s = 16'($signed(ir_in[5:0]));
            im = s; as = 1;
            rw = (ir_in[15:12] != 4'd4);
            mr = (ir_in[15:12] == 4'd3);
            mw = (ir_in[15:12] == 4'd4);
            rs = mw;
        end else if (ir_in[15:12] == 4'd5 || ir_in[15:12] == 4'd6) begin
            s = 16'($signed({ir_in[11:9], ir_in[2:0]}));
            im = s;
            jp = (ir_in[15:12] == 4'd5) ? (ca == cb) : (ca != cb);
        end else if (ir_in[15:12] == 4'd7) begin
            s = 16'($signed(ir_in[8:0]));
            im = s; rw = 1; op3 = 3'b110; jp = 1;
        end else if (ir_in[15:12] == 4'd8) begin
            im = {ir_in[8:0], 7'd0}; rw = 1; as = 1; op3 = 3'b110;
        end
        tgt = pc_in + im * 16'd2;
        return {rw, as, mw, mr, rs, op3, IPCP2, a1, a2, a3, im, f1, f2, fd, tgt, jp};
    endfunction

    // One cycle: predict, clock, update model, then pop and compare
    task automatic step(input string tag);
        vec_t e;
        sb_q.push_back(predict());
        @(posedge clk);
        if (rf_write && !loadAddr[3] && loadAddr[2:0] != 3'd0)
            mregs[loadAddr[2:0]] = loadData;
        #1;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            chk(tag, observed(), e);
        end
    endtask

    task automatic idle_inputs();
        IPCP2 = 0; pc_in = 0; ir_in = 0; loadAddr = 0; loadData = 0; rf_write = 0;
        comparatorMux1Control = 0; comparatorMux2Control = 0; comparatorMuxForward = 0;
    endtask

    initial begin
        vec_t zero;
        zero = '0;
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        idle_inputs();
        ir_in = 16'h7FFF; IPCP2 = 16'hBEEF;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("reset_hold", observed(), zero);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;

        // PC+2 pass-through with an R0 write that must be dropped
        IPCP2 = 16'd200; rf_write = 1; loadAddr = 4'd0; loadData = 16'hFFFF;
        step("pcp2");
        idle_inputs();
        pc_in = 16'd13;
        step("target_nop");

        // Write R3, then R-type read of R3 twice
        rf_write = 1; loadAddr = 4'd3; loadData = 16'h1234;
        step("write_r3");
        idle_inputs();
        ir_in = 16'h10D8;
        step("rtype_read_r3");
        // Write to upper address half is ignored
        rf_write = 1; loadAddr = 4'hB; loadData = 16'hDEAD; ir_in = 16'h10D8;
        step("ignored_hi_write");
        // Write-first bypass
        rf_write = 1; loadAddr = 4'd3; loadData = 16'h5678; ir_in = 16'h10D8;
        step("write_first");
        idle_inputs();

        // Branch scenario
        rf_write = 1; loadAddr = 4'd1; loadData = 16'd5; step("write_r1");
        rf_write = 1; loadAddr = 4'd2; loadData = 16'd5; step("write_r2");
        idle_inputs();
        ir_in = 16'h5E56; pc_in = 16'h0010;
        step("beq_taken");
        comparatorMux1Control = 1; comparatorMuxForward = 16'd6;
        step("beq_fwd_not_taken");
        ir_in = 16'h6E56;
        step("bne_fwd_taken");
        idle_inputs();
        // Target wrap and LUI / JAL / SW / LW / ADDI / high opcodes
        ir_in = 16'h70FF; pc_in = 16'hFFF0; step("jal_wrap");
        ir_in = 16'h81FF; pc_in = 16'h0100; step("lui");
        ir_in = 16'h4A60; step("sw");
        ir_in = 16'h325F; step("lw_neg");
        ir_in = 16'h2E5F; step("addi");
        ir_in = 16'hF1FF; step("op_f_nop");

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            IPCP2 = 16'($urandom); pc_in = 16'($urandom);
            ir_in = {4'($urandom_range(0, 9)), 12'($urandom)};
            rf_write = 1'($urandom); loadAddr = 4'($urandom); loadData = 16'($urandom);
            comparatorMux1Control = 1'($urandom);
            comparatorMux2Control = 1'($urandom);
            comparatorMuxForward = ($urandom_range(0, 1) == 1) ? mregs[ir_in[5:3]] : 16'($urandom);
            step("random");
        end
        idle_inputs();

        // Load R5, then asynchronous reset mid-cycle
        rf_write = 1; loadAddr = 4'd5; loadData = 16'hA5A5; ir_in = 16'h1F68;
        step("load_r5");
        #2 reset = 1'b1;
        #1 chk("async_reset", observed(), zero);
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        // Writes and input changes during reset must be ignored
        rf_write = 1; loadAddr = 4'd4; loadData = 16'h7777; ir_in = 16'h1F68; IPCP2 = 16'h9;
        @(posedge clk);
        #1 chk("reset_blocks_clk", observed(), zero);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        ir_in = 16'h1B60;  // rd=5 rs1=5 rs2=4
        step("regs_cleared");
        ir_in = 16'h1F68;  // rd=7 rs1=5 rs2=5
        step("regs_cleared2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
